// File: rtl/tap_bpm_ctrl.sv
// Tap-tempo sequencer: filters period samples, averages recent taps and divides into a saturated BPM.
// Build option: define TAPTEMPO_AVG_EN for 4-deep averaging; otherwise only the latest period is used.
module tap_bpm_ctrl #(
  parameter int PULSE_PER_NS = 5120,
  parameter int PER_MAX      = 62_600,
  parameter int PER_MIN      = 23_437,
  parameter int PER_W        = 17,
  parameter int BPM_MAX      = 250,
  parameter int BPM_W        = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PER_W-1:0] btn_per_i,
  input  logic             btn_per_valid_i,
  output logic [BPM_W-1:0] bpm_o,
  output logic             bpm_valid_o,
  output logic             busy_o
);

  localparam int NUM_W = 26;
  localparam int SUM_W = PER_W + 1;
  localparam longint unsigned DIVIDEND_L = 64'd60_000_000_000 / 64'(PULSE_PER_NS);
  localparam logic [NUM_W-1:0] DIVIDEND = NUM_W'(DIVIDEND_L);

`ifdef TAPTEMPO_AVG_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

  state_t           state, state_next;
  logic [PER_W-1:0] hist [DEPTH];
  logic [2:0]       n;
  logic [SUM_W-1:0] divisor;
  logic [SUM_W-1:0] rem;
  logic [NUM_W-1:0] quo;
  logic [4:0]       cnt;

  logic             strobe_timeout, strobe_accept;
  logic [SUM_W-1:0] sum_c;
  logic [NUM_W-1:0] num_c;
  logic [SUM_W:0]   shifted, trial;
  logic [NUM_W-1:0] quo_next;
  logic [SUM_W-1:0] rem_next;
  logic             last_bit;

  assign strobe_timeout = btn_per_valid_i && (btn_per_i >= PER_W'(PER_MAX));
  assign strobe_accept  = btn_per_valid_i && !strobe_timeout && (btn_per_i >= PER_W'(PER_MIN));
  assign last_bit       = (cnt == 5'(NUM_W - 1));
  assign busy_o         = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (strobe_accept) state_next = ACCUM;
      ACCUM:   state_next = DIV;
      DIV:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the n filled slots contribute; stale slots after a timeout are masked out.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < DEPTH; i++)
      if (3'(i) < n) sum_c = sum_c + SUM_W'(hist[i]);
  end

`ifdef TAPTEMPO_AVG_EN
  always_comb begin
    num_c = '0;
    if (n[0]) num_c = num_c + DIVIDEND;
    if (n[1]) num_c = num_c + (DIVIDEND << 1);
    if (n[2]) num_c = num_c + (DIVIDEND << 2);
  end
`else
  assign num_c = DIVIDEND;
`endif

  // Restoring step: the borrow bit of the trial subtraction decides the quotient bit.
  assign shifted  = {rem, quo[NUM_W-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign quo_next = {quo[NUM_W-2:0], ~trial[SUM_W]};
  assign rem_next = trial[SUM_W] ? shifted[SUM_W-1:0] : trial[SUM_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the history array is reset explicitly because averaging must restart from empty.
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      n           <= '0;
      divisor     <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      bpm_o       <= '0;
      bpm_valid_o <= 1'b0;
    end else begin
      bpm_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe_timeout) begin
            n <= '0;
          end else if (strobe_accept) begin
            for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= btn_per_i;
            if (n != 3'(DEPTH)) n <= n + 3'd1;
          end
        end
        ACCUM: begin
          divisor <= sum_c;
          rem     <= '0;
          quo     <= num_c;
          cnt     <= '0;
        end
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 5'd1;
          if (last_bit) begin
            bpm_o       <= (quo_next > NUM_W'(BPM_MAX)) ? BPM_W'(BPM_MAX) : quo_next[BPM_W-1:0];
            bpm_valid_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_bpm_ctrl.sv
// Scoreboard bench for tap_bpm_ctrl: stimulus pushes expected BPM and arrival cycle, a monitor pops on bpm_valid_o.
module tb_tap_bpm_ctrl;

`ifdef TAPTEMPO_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [16:0] btn_per_i;
  logic        btn_per_valid_i;
  logic [8:0]  bpm_o;
  logic        bpm_valid_o;
  logic        busy_o;

  tap_bpm_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .btn_per_i       (btn_per_i),
    .btn_per_valid_i (btn_per_valid_i),
    .bpm_o           (bpm_o),
    .bpm_valid_o     (bpm_valid_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned bpm;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        prev_valid = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (bpm_valid_o) begin
      check("valid_not_back_to_back", prev_valid, 0);
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bpm", bpm_o, e.bpm);
        check("latency_cycle", cyc, e.cyc);
      end
    end
    prev_valid <= bpm_valid_o;
  end

  task automatic strobe(input int per, input bit expect_out, input int exp_bpm, output int unsigned k);
    exp_t e;
    @(posedge clk_i);
    #1;
    btn_per_i       = 17'(per);
    btn_per_valid_i = 1'b1;
    k = cyc;
    if (expect_out) begin
      e.bpm = exp_bpm;
      e.cyc = k + 28;
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    btn_per_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk_i);
      #1;
      if (!busy_o && sb.size() == 0) done = 1'b1;
    end
    if (!done) check({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int unsigned k;
    rst_i           = 1'b1;
    btn_per_i       = '0;
    btn_per_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_bpm", bpm_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_valid", bpm_valid_o, 0);
    rst_i = 1'b0;

    // T1: timeout sample produces nothing
    strobe(62600, 0, 0, k);
    check("timeout_busy", busy_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    check("timeout_busy_later", busy_o, 0);

    // T2 / T3
    strobe(46875, 1, 250, k);
    wait_idle("t2");
    strobe(62500, 1, AVG ? 214 : 187, k);
    wait_idle("t3");

    // T4: saturation, then glitch ignored with output held
    strobe(62600, 0, 0, k);
    strobe(39062, 1, 250, k);
    wait_idle("t4");
    strobe(100, 0, 0, k);
    check("glitch_busy", busy_o, 0);
    repeat (35) @(posedge clk_i);
    #1;
    check("glitch_bpm_held", bpm_o, 250);

    // Boundaries around PER_MIN and just below PER_MAX
    strobe(62600, 0, 0, k);
    strobe(23436, 0, 0, k);
    check("below_min_busy", busy_o, 0);
    strobe(23437, 1, 250, k);
    wait_idle("at_min");
    strobe(62600, 0, 0, k);
    strobe(62599, 1, 187, k);
    wait_idle("below_max");

    // History depth: four equal taps, then a fifth pushes the oldest out
    strobe(62600, 0, 0, k);
    for (int i = 0; i < 4; i++) begin
      strobe(50000, 1, 234, k);
      wait_idle("depth");
    end
    strobe(60000, 1, AVG ? 223 : 195, k);
    wait_idle("depth5");

    // T5: strobe while busy is dropped and never enters history
    strobe(62600, 0, 0, k);
    strobe(46875, 1, 250, k);
    repeat (3) @(posedge clk_i);
    strobe(23437, 0, 0, k);
    wait_idle("t5a");
    strobe(62500, 1, AVG ? 214 : 187, k);
    wait_idle("t5b");

    // T6: reset at cycle 10 of DIV aborts without a pulse and clears history
    strobe(40000, 0, 0, k);
    while (cyc < k + 12) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check("midreset_bpm", bpm_o, 0);
    check("midreset_busy", busy_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    check("post_reset_busy", busy_o, 0);
    strobe(62500, 1, 187, k);
    wait_idle("post_reset");

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
